zuart_rx: RTL and testbench

UART receiver for the debug/upload link, the receive-direction counterpart of ZUART_Tx on the DPU UART (iDPU_RX pin).
- Frame format: 8N1, LSB first.
- Bit timing: parameter-defined clocks per bit; decisions use a 3-sample majority vote.
- Output: one-entry holding register with a valid/ack handshake, plus framing-error, overrun and break flags.
- A downstream command parser consumes received bytes on iClk (clk_100MHz).

---
 rtl/zuart_rx_pkg.sv | 19 +
 rtl/zuart_rx_sampler.sv | 38 +++
 rtl/zuart_rx.sv | 153 +++++++++++++++
 tb/tb_zuart_rx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/zuart_rx_pkg.sv
// Shared types and helpers for the zuart_rx receiver.
package zuart_rx_pkg;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_IDLE = 3'd4
  } rx_state_e;

  localparam int CNT_W  = 16;
  localparam int BIDX_W = 4;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/zuart_rx_sampler.sv
// Line conditioning for zuart_rx: 2-FF synchronizer plus two held samples
// that are voted against the live synchronized value at the decision point.
module zuart_rx_sampler
  import zuart_rx_pkg::*;
(
  input  logic iClk,
  input  logic iRst,
  input  logic i_rxd,
  input  logic i_smp0,
  input  logic i_smp1,
  output logic o_rxs,
  output logic o_maj
);

  logic r_sync1;
  logic r_sync2;
  logic r_smp0;
  logic r_smp1;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_smp0  <= 1'b1;
      r_smp1  <= 1'b1;
    end else begin
      r_sync1 <= i_rxd;
      r_sync2 <= r_sync1;
      if (i_smp0) r_smp0 <= r_sync2;
      if (i_smp1) r_smp1 <= r_sync2;
    end
  end

  // Third sample is the current rxs, so the vote is ready on the decision cycle.
  assign o_rxs = r_sync2;
  assign o_maj = maj3(r_smp0, r_smp1, r_sync2);

endmodule

// File: rtl/zuart_rx.sv
// 8N1 UART receiver with majority-vote bit decisions, a one-entry holding
// register (valid/ack), and framing-error, overrun and break reporting.
//
// state        | meaning
// RX_IDLE      | line idle, waiting for rxs low
// RX_START     | qualifying start bit; high vote rejects it as a glitch
// RX_DATA      | assembling 8 data bits LSB first
// RX_STOP      | stop-bit vote; deliver byte or flag framing error
// RX_WAIT_IDLE | after a framing error, wait for the line to go high
module zuart_rx
  import zuart_rx_pkg::*;
#(
  parameter int Freq_divider = 100
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iRxD,
  output logic [7:0] oData,
  output logic       oValid,
  input  logic       iAck,
  output logic       oFrameErr,
  output logic       oOverrun,
  output logic       oBreak,
  output logic       oBusy
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(Freq_divider - 1);
  localparam logic [CNT_W-1:0] C_S0   = CNT_W'(Freq_divider / 2 - 1);
  localparam logic [CNT_W-1:0] C_S1   = CNT_W'(Freq_divider / 2);
  localparam logic [CNT_W-1:0] C_DEC  = CNT_W'(Freq_divider / 2 + 1);

  rx_state_e         r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [BIDX_W-1:0] r_bidx;
  logic [7:0]        r_shreg;
  logic [7:0]        r_data;
  logic              r_valid;
  logic              r_fe;
  logic              r_ovr;
  logic              r_brk;

  logic w_rxs;
  logic w_maj;
  logic w_active;
  logic w_smp0;
  logic w_smp1;
  logic w_dec;

  assign w_active = (r_state == RX_START) || (r_state == RX_DATA) || (r_state == RX_STOP);
  assign w_smp0   = w_active && (r_cnt == C_S0);
  assign w_smp1   = w_active && (r_cnt == C_S1);
  assign w_dec    = (r_cnt == C_DEC);

  zuart_rx_sampler u_sampler (
    .iClk   (iClk),
    .iRst   (iRst),
    .i_rxd  (iRxD),
    .i_smp0 (w_smp0),
    .i_smp1 (w_smp1),
    .o_rxs  (w_rxs),
    .o_maj  (w_maj)
  );

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bidx  <= '0;
      r_shreg <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_fe    <= 1'b0;
      r_ovr   <= 1'b0;
      r_brk   <= 1'b0;
    end else begin
      r_fe  <= 1'b0;
      r_ovr <= 1'b0;
      // A delivery below overrides this clear when both land together.
      if (iAck && r_valid) r_valid <= 1'b0;

      case (r_state)
        RX_IDLE: begin
          if (!w_rxs) begin
            r_state <= RX_START;
            r_cnt   <= '0;
            r_bidx  <= '0;
          end
        end
        RX_START: begin
          if (w_dec && w_maj) begin
            r_state <= RX_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == C_LAST) begin
            r_state <= RX_DATA;
            r_cnt   <= '0;
            r_bidx  <= BIDX_W'(1);
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (w_dec) r_shreg <= {w_maj, r_shreg[7:1]};
          if (r_cnt == C_LAST) begin
            r_cnt  <= '0;
            r_bidx <= r_bidx + 1'b1;
            if (r_bidx == BIDX_W'(8)) r_state <= RX_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          // Decide mid stop bit so the next start edge can be caught early.
          if (w_dec) begin
            r_cnt <= '0;
            if (w_maj) begin
              r_state <= RX_IDLE;
              if (!r_valid || iAck) begin
                r_data  <= r_shreg;
                r_valid <= 1'b1;
              end else begin
                r_ovr <= 1'b1;
              end
            end else begin
              r_fe    <= 1'b1;
              r_state <= RX_WAIT_IDLE;
              if (r_shreg == 8'h00) r_brk <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_WAIT_IDLE: begin
          if (w_rxs) begin
            r_brk   <= 1'b0;
            r_state <= RX_IDLE;
          end
        end
        default: begin
          r_state <= RX_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign oData     = r_data;
  assign oValid    = r_valid;
  assign oFrameErr = r_fe;
  assign oOverrun  = r_ovr;
  assign oBreak    = r_brk;
  assign oBusy     = (r_state != RX_IDLE);

endmodule

// File: tb/tb_zuart_rx.sv
// Directed bench for zuart_rx at 100 clocks per bit.
module tb_zuart_rx;

  localparam int D = 100;

  logic       iClk = 1'b0;
  logic       iRst = 1'b1;
  logic       iRxD = 1'b1;
  logic       iAck = 1'b0;
  logic [7:0] oData;
  logic       oValid;
  logic       oFrameErr;
  logic       oOverrun;
  logic       oBreak;
  logic       oBusy;

  int n_checks = 0;
  int n_errors = 0;

  int         rise_i;
  logic [7:0] rise_data;
  int         n_fe;
  int         n_ovr;
  int         n_brk_hi;
  int         n_valid_seen;
  int         n_busy_seen;

  always #5 iClk = ~iClk;

  zuart_rx #(.Freq_divider(D)) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iRxD      (iRxD),
    .oData     (oData),
    .oValid    (oValid),
    .iAck      (iAck),
    .oFrameErr (oFrameErr),
    .oOverrun  (oOverrun),
    .oBreak    (oBreak),
    .oBusy     (oBusy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  function automatic logic [19:0] frm(input logic [7:0] d, input logic stop);
    return {10'h3ff, stop, d, 1'b0};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, 32'(oData), 32'h00);
    check({tag, "_valid"}, 32'(oValid), 32'h0);
    check({tag, "_fe"}, 32'(oFrameErr), 32'h0);
    check({tag, "_ovr"}, 32'(oOverrun), 32'h0);
    check({tag, "_brk"}, 32'(oBreak), 32'h0);
    check({tag, "_busy"}, 32'(oBusy), 32'h0);
  endtask

  // Drives nbits bit periods (bits[0] first); index i counts edges from the
  // first edge that samples bits[0]. Line returns high after the last bit.
  task automatic drive(input logic [19:0] bits, input int nbits, input int ack_at,
                       input int rst_at);
    logic prev_v;
    int   nb;
    rise_i    = -1;
    rise_data = 8'h00;
    n_fe      = 0;
    n_ovr     = 0;
    n_brk_hi  = 0;
    prev_v    = oValid;
    iRxD      = bits[0];
    for (int i = 0; i < nbits * D; i++) begin
      tick();
      if (iAck) iAck = 1'b0;
      if (oValid && !prev_v && rise_i < 0) begin
        rise_i    = i;
        rise_data = oData;
      end
      prev_v = oValid;
      if (oFrameErr) n_fe++;
      if (oOverrun) n_ovr++;
      if (oBreak) n_brk_hi++;
      if (i == ack_at) iAck = 1'b1;
      if (i == rst_at) iRst = 1'b1;
      if (rst_at >= 0 && i == rst_at + 5) check_reset_outputs("midrst");
      if ((i + 1) % D == 0) begin
        nb   = (i + 1) / D;
        iRxD = (nb < nbits) ? bits[nb] : 1'b1;
      end
    end
    iRxD = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset
    iRst = 1'b1;
    idle(3);
    check_reset_outputs("reset");
    iRst = 1'b0;
    idle(10);

    // Two clean frames, each acked on the first cycle oValid is high
    drive(frm(8'h55, 1'b1), 10, 954, -1);
    check("t1a_lat", 32'(rise_i), 32'd954);
    check("t1a_data", 32'(rise_data), 32'h55);
    check("t1a_flags", 32'(n_fe + n_ovr + n_brk_hi), 32'd0);
    check("t1a_acked", 32'(oValid), 32'h0);
    drive(frm(8'hA3, 1'b1), 10, 954, -1);
    check("t1b_lat", 32'(rise_i), 32'd954);
    check("t1b_data", 32'(rise_data), 32'hA3);
    check("t1b_flags", 32'(n_fe + n_ovr + n_brk_hi), 32'd0);
    check("t1b_acked", 32'(oValid), 32'h0);

    // 30-cycle glitch is rejected at the start-bit vote
    n_valid_seen = 0;
    n_busy_seen  = 0;
    n_fe         = 0;
    iRxD = 1'b0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (i == 29) iRxD = 1'b1;
      if (oValid) n_valid_seen++;
      if (oBusy) n_busy_seen++;
      if (oFrameErr || oOverrun || oBreak) n_fe++;
    end
    check("t2_busy_seen", 32'(n_busy_seen > 0), 32'h1);
    check("t2_busy_end", 32'(oBusy), 32'h0);
    check("t2_valid", 32'(n_valid_seen), 32'd0);
    check("t2_flags", 32'(n_fe), 32'd0);
    drive(frm(8'h0F, 1'b1), 10, 954, -1);
    check("t2_lat", 32'(rise_i), 32'd954);
    check("t2_data", 32'(rise_data), 32'h0F);

    // Framing error on a non-zero byte
    drive(frm(8'h81, 1'b0), 10, -1, -1);
    check("t3_fe", 32'(n_fe), 32'd1);
    check("t3_valid", 32'(oValid), 32'h0);
    check("t3_brk", 32'(n_brk_hi), 32'd0);
    idle(5);
    check("t3_busy", 32'(oBusy), 32'h0);

    // Break: line low for 20 bit times
    drive(20'h00000, 20, -1, -1);
    check("t4_fe", 32'(n_fe), 32'd1);
    check("t4_brk_cycles", 32'(n_brk_hi), 32'd1046);
    check("t4_valid", 32'(oValid), 32'h0);
    tick();
    check("t4_brk_j0", 32'(oBreak), 32'h1);
    tick();
    check("t4_brk_j1", 32'(oBreak), 32'h1);
    tick();
    check("t4_brk_j2", 32'(oBreak), 32'h0);
    idle(10);
    check("t4_busy", 32'(oBusy), 32'h0);

    // Overrun, then replacement with ack on the delivery cycle
    drive(frm(8'h11, 1'b1), 10, -1, -1);
    check("t5_lat", 32'(rise_i), 32'd954);
    check("t5_data1", 32'(oData), 32'h11);
    drive(frm(8'h22, 1'b1), 10, -1, -1);
    check("t5_ovr", 32'(n_ovr), 32'd1);
    check("t5_keep", 32'(oData), 32'h11);
    check("t5_valid", 32'(oValid), 32'h1);
    drive(frm(8'h22, 1'b1), 10, 953, -1);
    check("t5b_ovr", 32'(n_ovr), 32'd0);
    check("t5b_data", 32'(oData), 32'h22);
    check("t5b_valid", 32'(oValid), 32'h1);
    check("t5b_norise", 32'(rise_i), 32'hFFFFFFFF);
    iAck = 1'b1;
    tick();
    iAck = 1'b0;
    tick();
    check("t5_cleared", 32'(oValid), 32'h0);

    // Reset during data bit 4, held until the frame has ended
    drive(frm(8'hC3, 1'b1), 10, -1, 420);
    idle(2);
    iRst = 1'b0;
    idle(10);
    check("t6_norise", 32'(rise_i), 32'hFFFFFFFF);
    check("t6_fe", 32'(n_fe), 32'd0);
    check_reset_outputs("t6_after");
    drive(frm(8'h3C, 1'b1), 10, 954, -1);
    check("t6_lat", 32'(rise_i), 32'd954);
    check("t6_data", 32'(rise_data), 32'h3C);
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
